// File: rtl/txts_queue_ctrl_pkg.sv
// Shared definitions for the tx timestamp queue: entry field widths,
// interrupt FSM encodings and PTP messageType constants.
package txts_queue_ctrl_pkg;

  localparam int TS_W      = 80;
  localparam int SEQID_W   = 16;
  localparam int MSGTYPE_W = 4;
  localparam int ENTRY_W   = TS_W + SEQID_W + MSGTYPE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ERR  = 2'd2
  } irq_state_t;

  localparam logic [MSGTYPE_W-1:0] MSG_SYNC        = 4'd0;
  localparam logic [MSGTYPE_W-1:0] MSG_DELAY_REQ   = 4'd1;
  localparam logic [MSGTYPE_W-1:0] MSG_PDELAY_REQ  = 4'd2;
  localparam logic [MSGTYPE_W-1:0] MSG_PDELAY_RESP = 4'd3;

endpackage

// File: rtl/txts_queue_mem.sv
// Timestamp queue storage: DEPTH x ENTRY_W register array, registered write,
// combinational read. Contents are deliberately not reset.
module txts_queue_mem
  import txts_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/txts_queue_ctrl.sv
// PTP tx timestamp capture queue with overflow tracking and interrupt.
// Optional messageType filtering is enabled by defining TXTS_TYPE_FILTER_EN.
//
// state | meaning
// IDLE  | queue empty, no overflow pending
// PEND  | entries present, no overflow pending
// ERR   | overflow flag set (a capture was dropped)
module txts_queue_ctrl
  import txts_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       rtc_clk,
  input  logic                       rtc_rst_n,
  input  logic                       txts_valid_i,
  input  logic [TS_W-1:0]            txts_ts_i,
  input  logic [SEQID_W-1:0]         txts_seqid_i,
  input  logic [MSGTYPE_W-1:0]       txts_msgtype_i,
  input  logic                       cfg_en_i,
  input  logic                       cfg_int_en_i,
  input  logic [15:0]                cfg_type_mask_i,
  input  logic                       flush_i,
  input  logic                       pop_i,
  input  logic                       clr_ovf_i,
  output logic                       head_valid_o,
  output logic [TS_W-1:0]            head_ts_o,
  output logic [SEQID_W-1:0]         head_seqid_o,
  output logic [MSGTYPE_W-1:0]       head_msgtype_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic                       int_txts_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ovf_q;
  logic [CNT_W-1:0]   drop_cnt_q;
  logic               int_q;
  irq_state_t         state_q, state_d;
  logic               type_ok, capture, full, empty;
  logic               pop_ok, push_ok, drop;
  logic [ENTRY_W-1:0] head_entry;

`ifdef TXTS_TYPE_FILTER_EN
  assign type_ok = cfg_type_mask_i[txts_msgtype_i];
`else
  logic unused_type_mask;
  assign unused_type_mask = ^cfg_type_mask_i;
  assign type_ok = 1'b1;
`endif

  assign capture = txts_valid_i & cfg_en_i & type_ok;
  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop_i & ~empty & ~flush_i;
  // A same-cycle pop frees a slot, so a full queue still accepts the push.
  assign push_ok = capture & ~flush_i & (~full | pop_ok);
  assign drop    = capture & ~flush_i & full & ~pop_ok;

  always_comb begin
    level_d = level_q;
    if (flush_i)               level_d = '0;
    else if (push_ok & ~pop_ok) level_d = level_q + LVL_W'(1);
    else if (pop_ok & ~push_ok) level_d = level_q - LVL_W'(1);
  end

  txts_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk   (rtc_clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata ({txts_ts_i, txts_seqid_i, txts_msgtype_i}),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      int_q      <= 1'b0;
    end else begin
      level_q <= level_d;
      int_q   <= cfg_int_en_i & (~empty | ovf_q);
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      // A drop coinciding with a clear restarts the count at one.
      if (drop) begin
        ovf_q      <= 1'b1;
        drop_cnt_q <= clr_ovf_i ? CNT_W'(1) :
                      (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
      end else if (clr_ovf_i) begin
        ovf_q      <= 1'b0;
        drop_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (drop) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_IDLE: if (level_d != '0) state_d = ST_PEND;
        ST_PEND: if (level_d == '0) state_d = ST_IDLE;
        ST_ERR:  if (clr_ovf_i) state_d = (level_d != '0) ? ST_PEND : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign head_valid_o   = ~empty;
  assign head_ts_o      = head_entry[ENTRY_W-1 -: TS_W];
  assign head_seqid_o   = head_entry[MSGTYPE_W +: SEQID_W];
  assign head_msgtype_o = head_entry[MSGTYPE_W-1:0];
  assign level_o        = level_q;
  assign ovf_o          = ovf_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign int_txts_o     = int_q;

endmodule

// File: tb/tb_txts_queue_ctrl.sv
// Directed bench for txts_queue_ctrl with a queue-based reference scoreboard.
module tb_txts_queue_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic        rtc_clk = 1'b0;
  logic        rtc_rst_n;
  logic        txts_valid_i;
  logic [79:0] txts_ts_i;
  logic [15:0] txts_seqid_i;
  logic [3:0]  txts_msgtype_i;
  logic        cfg_en_i, cfg_int_en_i;
  logic [15:0] cfg_type_mask_i;
  logic        flush_i, pop_i, clr_ovf_i;
  logic        head_valid_o;
  logic [79:0] head_ts_o;
  logic [15:0] head_seqid_o;
  logic [3:0]  head_msgtype_o;
  logic [2:0]  level_o;
  logic        ovf_o;
  logic [7:0]  drop_cnt_o;
  logic        int_txts_o;

  txts_queue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .rtc_clk(rtc_clk), .rtc_rst_n(rtc_rst_n),
    .txts_valid_i(txts_valid_i), .txts_ts_i(txts_ts_i),
    .txts_seqid_i(txts_seqid_i), .txts_msgtype_i(txts_msgtype_i),
    .cfg_en_i(cfg_en_i), .cfg_int_en_i(cfg_int_en_i),
    .cfg_type_mask_i(cfg_type_mask_i), .flush_i(flush_i), .pop_i(pop_i),
    .clr_ovf_i(clr_ovf_i), .head_valid_o(head_valid_o), .head_ts_o(head_ts_o),
    .head_seqid_o(head_seqid_o), .head_msgtype_o(head_msgtype_o),
    .level_o(level_o), .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o),
    .int_txts_o(int_txts_o)
  );

  always #5 rtc_clk = ~rtc_clk;

  int errors = 0;
  int checks = 0;

  logic [99:0] sb_q[$];
  logic        m_ovf;
  logic [7:0]  m_cnt;
  logic        m_int;

  function automatic logic [79:0] mk_ts(input logic [15:0] s);
    return {16'hC0DE, s, 16'h5A5A, ~s, 16'hBEEF};
  endfunction

  task automatic check(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":level"}, 100'(level_o), 100'(sb_q.size()));
    check({tag, ":head_valid"}, 100'(head_valid_o), 100'(sb_q.size() > 0));
    if (sb_q.size() > 0)
      check({tag, ":head"}, {head_ts_o, head_seqid_o, head_msgtype_o}, sb_q[0]);
    check({tag, ":ovf"}, 100'(ovf_o), 100'(m_ovf));
    check({tag, ":drop_cnt"}, 100'(drop_cnt_o), 100'(m_cnt));
    check({tag, ":int"}, 100'(int_txts_o), 100'(m_int));
  endtask

  task automatic step(input bit v, input logic [15:0] s, input logic [3:0] t,
                      input bit p, input bit f, input bit c, input string tag);
    bit cap, full, pop_ok, type_ok, n_int;
    txts_valid_i = v; txts_seqid_i = s; txts_msgtype_i = t;
    txts_ts_i = mk_ts(s);
    pop_i = p; flush_i = f; clr_ovf_i = c;
`ifdef TXTS_TYPE_FILTER_EN
    type_ok = cfg_type_mask_i[t];
`else
    type_ok = 1'b1;
`endif
    n_int  = cfg_int_en_i & ((sb_q.size() > 0) | m_ovf);
    cap    = v & cfg_en_i & type_ok;
    full   = (sb_q.size() == DEPTH);
    pop_ok = p & (sb_q.size() > 0);
    @(posedge rtc_clk);
    #1;
    m_int = n_int;
    if (f) begin
      sb_q.delete();
    end else begin
      if (pop_ok) void'(sb_q.pop_front());
      if (cap && (!full || pop_ok)) sb_q.push_back({mk_ts(s), s, t});
    end
    if (cap && !f && full && !pop_ok) begin
      m_ovf = 1'b1;
      m_cnt = c ? 8'd1 : (m_cnt == 8'hFF ? 8'hFF : m_cnt + 8'd1);
    end else if (c) begin
      m_ovf = 1'b0;
      m_cnt = 8'd0;
    end
    txts_valid_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clr_ovf_i = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ovf = 1'b0; m_cnt = 8'd0; m_int = 1'b0;
  endtask

  initial begin
    rtc_rst_n = 1'b0;
    txts_valid_i = 1'b0; txts_ts_i = '0; txts_seqid_i = '0; txts_msgtype_i = '0;
    cfg_en_i = 1'b1; cfg_int_en_i = 1'b1; cfg_type_mask_i = 16'hFFFF;
    flush_i = 1'b0; pop_i = 1'b0; clr_ovf_i = 1'b0;
    model_reset();
    repeat (3) @(posedge rtc_clk);
    #2 rtc_rst_n = 1'b1;
    @(posedge rtc_clk); #1;
    check_all("reset");

    // basic ordering
    step(1, 16'h0001, 4'd0, 0, 0, 0, "push1");
    step(1, 16'h0002, 4'd1, 0, 0, 0, "push2");
    step(1, 16'h0003, 4'd2, 0, 0, 0, "push3");
    check("three_level", 100'(level_o), 100'd3);
    check("three_head", 100'(head_seqid_o), 100'h0001);
    step(0, 0, 0, 1, 0, 0, "pop_a");
    step(0, 0, 0, 1, 0, 0, "pop_b");
    check("after_2pop_head", 100'(head_seqid_o), 100'h0003);
    step(0, 0, 0, 1, 0, 0, "pop_last");
    step(0, 0, 0, 1, 0, 0, "pop_empty");
    step(0, 0, 0, 0, 0, 0, "int_drop");

    // overflow with five captures
    for (int i = 0; i < 5; i++) step(1, 16'h0010 + 16'(i), 4'd3, 0, 0, 0, "fill");
    check("ovf_cnt", 100'(drop_cnt_o), 100'd1);
    check("ovf_head", 100'(head_seqid_o), 100'h0010);
    step(0, 0, 0, 0, 0, 0, "ovf_int");
    check("ovf_int_hi", 100'(int_txts_o), 100'd1);

    // full queue: pop and push together
    step(1, 16'h0020, 4'd0, 1, 0, 0, "full_pushpop");
    check("full_pp_level", 100'(level_o), 100'd4);
    check("full_pp_cnt", 100'(drop_cnt_o), 100'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, "drain");
    check("new_at_head", 100'(head_seqid_o), 100'h0020);

    // saturation of the drop counter
    for (int i = 0; i < 3; i++) step(1, 16'h0030 + 16'(i), 4'd1, 0, 0, 0, "refill");
    for (int i = 0; i < 300; i++) step(1, 16'h0100 + 16'(i), 4'd1, 0, 0, 0, "sat");
    check("sat_cnt", 100'(drop_cnt_o), 100'hFF);
    step(0, 0, 0, 0, 0, 1, "clr");
    check("clr_cnt", 100'(drop_cnt_o), 100'h00);
    check("clr_ovf", 100'(ovf_o), 100'd0);
    step(1, 16'h0200, 4'd1, 0, 0, 1, "clr_and_drop");
    check("clr_drop_cnt", 100'(drop_cnt_o), 100'd1);

    // disable keeps entries, interrupt gating
    cfg_en_i = 1'b0;
    step(0, 0, 0, 1, 0, 0, "dis_pop");
    step(1, 16'h0300, 4'd0, 0, 0, 0, "dis_push");
    cfg_en_i = 1'b1;
    cfg_int_en_i = 1'b0;
    step(0, 0, 0, 0, 0, 0, "int_off");
    cfg_int_en_i = 1'b1;

    // flush with a coincident push
    step(1, 16'h0400, 4'd0, 0, 1, 0, "flush_push");
    check("flush_level", 100'(level_o), 100'd0);
    check("flush_hv", 100'(head_valid_o), 100'd0);
    step(0, 0, 0, 0, 0, 1, "clr2");

    // asynchronous reset mid-traffic
    step(1, 16'h0500, 4'd0, 0, 0, 0, "pre_rst_a");
    step(1, 16'h0501, 4'd0, 1, 0, 0, "pre_rst_b");
    #2 rtc_rst_n = 1'b0;
    #1;
    check("rst_level", 100'(level_o), 100'd0);
    check("rst_hv", 100'(head_valid_o), 100'd0);
    check("rst_ovf", 100'(ovf_o), 100'd0);
    check("rst_cnt", 100'(drop_cnt_o), 100'd0);
    check("rst_int", 100'(int_txts_o), 100'd0);
    model_reset();
    @(posedge rtc_clk);
    #2 rtc_rst_n = 1'b1;
    step(1, 16'h0600, 4'd2, 0, 0, 0, "post_rst");
    check("post_rst_head", 100'(head_seqid_o), 100'h0600);

    // messageType filter (mask ignored in the default build)
    step(0, 0, 0, 0, 1, 0, "flush2");
    cfg_type_mask_i = 16'h0001;
    step(1, 16'h0700, 4'd0, 0, 0, 0, "type0");
    step(1, 16'h0701, 4'd1, 0, 0, 0, "type1");
`ifdef TXTS_TYPE_FILTER_EN
    check("filt_level", 100'(level_o), 100'd1);
`else
    check("filt_level", 100'(level_o), 100'd2);
`endif
    check("filt_cnt", 100'(drop_cnt_o), 100'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/txts_queue_ctrl.md
TXTS_QUEUE_CTRL -- requirements
Module: txts_queue_ctrl

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- DEPTH, 4, queue entries; power of two, 2..16.
- CNT_W, 8, drop-counter width.
REQ-002 The block SHALL have ports, one per line: name  direction  width  meaning. Clock and reset are listed first.
- rtc_clk  in  1  single clock.
- rtc_rst_n  in  1  asynchronous active-low reset.
- txts_valid_i  in  1  one-cycle pulse: tx timestamp and message fields valid.
- txts_ts_i  in  80  48-bit seconds + 32-bit ns.
- txts_seqid_i  in  16  PTP sequenceId.
- txts_msgtype_i  in  4  PTP messageType.
- cfg_en_i  in  1  queue enable; 0 = captures ignored.
- cfg_int_en_i  in  1  interrupt enable.
- cfg_type_mask_i  in  16  bit n = capture messageType n (used only with filter).
- flush_i  in  1  pulse: empty the queue.
- pop_i  in  1  pulse: consume the head entry.
- clr_ovf_i  in  1  pulse: clear the overflow flag and the drop counter.
- head_valid_o  out  1  queue not empty.
- head_ts_o  out  80  head timestamp.
- head_seqid_o  out  16  head sequenceId.
- head_msgtype_o  out  4  head messageType.
- level_o  out  clog2(DEPTH)+1  current occupancy.
- ovf_o  out  1  sticky: capture dropped because the queue was full.
- drop_cnt_o  out  CNT_W  saturating count of dropped captures.
- int_txts_o  out  1  registered interrupt.

Function
REQ-003 On txts_valid_i with cfg_en_i=1, the block SHALL write {ts, seqid, msgtype} at the write pointer when not full, and occupancy SHALL increment on the next edge.
REQ-004 When full, the block SHALL drop the new capture, set ovf_o, and increment drop_cnt_o; drop_cnt_o SHALL saturate at all-ones.
REQ-005 Head outputs SHALL show the read-pointer entry combinationally from registered storage; head_valid_o SHALL assert one cycle after the first accepted write.
REQ-006 pop_i with head_valid_o=1 SHALL advance the read pointer; pop_i when empty SHALL be ignored with no state change.
REQ-007 Simultaneous accepted push and pop SHALL leave occupancy unchanged. When full, the pop SHALL be honoured first, so the push is accepted and no drop occurs.
REQ-008 Pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be derived from a separate occupancy counter.
REQ-009 flush_i SHALL take priority over push and pop in the same cycle: pointers and occupancy go to 0, the same-cycle capture is discarded, and ovf_o and drop_cnt_o are unchanged.
REQ-010 clr_ovf_i SHALL zero ovf_o and drop_cnt_o. A drop in the same cycle SHALL win, giving ovf_o=1 and drop_cnt_o=1.
REQ-011 int_txts_o SHALL be registered as cfg_int_en_i & (head_valid_o | ovf_o), giving one cycle of latency.
REQ-012 An interrupt-state FSM SHALL have states IDLE (empty, no ovf), PEND (entries present), and ERR (ovf_o set).
- IDLE->PEND on first push.
- PEND->IDLE when the last entry is popped or the queue is flushed.
- Any state->ERR on a drop.
- ERR->PEND or IDLE on clr_ovf_i, according to occupancy.
REQ-013 cfg_en_i falling SHALL NOT clear stored entries.

Reset
REQ-014 Asynchronous assertion of rtc_rst_n SHALL clear, with deassertion taking effect on a rising rtc_clk edge:
- pointers and occupancy to 0;
- FSM to IDLE;
- ovf_o=0, drop_cnt_o=0, int_txts_o=0, head_valid_o=0.
Storage array contents need not be reset; head data outputs are don't-care while head_valid_o=0.
REQ-015 Reset mid-operation SHALL discard all queued entries; the first capture after reset SHALL land in entry 0.

Configuration
REQ-016 With TXTS_TYPE_FILTER_EN defined, a capture SHALL be accepted only if cfg_type_mask_i[txts_msgtype_i]=1. Filtered captures SHALL be neither stored nor counted as drops.
REQ-017 Without TXTS_TYPE_FILTER_EN, cfg_type_mask_i SHALL be ignored and every valid capture is a candidate.

Structure
REQ-018 The shared package/defines SHALL hold:
- entry field widths (80/16/4);
- FSM state encodings;
- PTP messageType constants (Sync=0, Delay_Req=1, Pdelay_Req=2, Pdelay_Resp=3).
REQ-019 Storage SHALL be one sub-module, txts_queue_mem (DEPTH x 100-bit register array with registered write and combinational read); control logic stays in txts_queue_ctrl.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Push seqid 0x0001..0x0003, no pop -> level_o=3, head_seqid_o=0x0001. Pop twice -> head_seqid_o=0x0003.
- DEPTH=4: push 5 captures -> level_o=4, ovf_o=1, drop_cnt_o=1, head_seqid_o=first seqid, int_txts_o=1 one cycle after the drop.
- Full queue, pop_i and txts_valid_i in the same cycle -> level_o stays 4, drop_cnt_o unchanged, new entry appears after 3 further pops.
- 300 drops with CNT_W=8 -> drop_cnt_o=0xFF. clr_ovf_i -> 0x00, ovf_o=0.
- flush_i coincident with push -> level_o=0, head_valid_o=0 next cycle. Assert rtc_rst_n mid-traffic -> all outputs at reset values immediately.
- TXTS_TYPE_FILTER_EN defined, mask=0x0001: push msgtype 0 then 1 -> level_o=1, drop_cnt_o=0.
